// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Counter widths cover the parameter maxima (MAX_BURST <= 15, READ_LATENCY <= 7).
  localparam int unsigned BURST_W = 4;
  localparam int unsigned LAT_W   = 3;

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and memory-bus signals of the arbiter; slave = arbiter side.
interface memory_arbiter_if;

  logic        req_0_valid;
  logic [15:0] req_0_address;
  logic        req_0_write_enable;
  logic [15:0] req_0_data_in;
  logic        req_0_ready;
  logic [15:0] req_0_data_out;

  logic        req_1_valid;
  logic [15:0] req_1_address;
  logic        req_1_write_enable;
  logic [15:0] req_1_data_in;
  logic        req_1_ready;
  logic [15:0] req_1_data_out;

  logic [15:0] mem_address;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_bus_enable;
  logic        mem_write_enable;
  logic        owner;

  modport slave (
    input  req_0_valid, req_0_address, req_0_write_enable, req_0_data_in,
    input  req_1_valid, req_1_address, req_1_write_enable, req_1_data_in,
    input  mem_data_out,
    output req_0_ready, req_0_data_out, req_1_ready, req_1_data_out,
    output mem_address, mem_data_in, mem_bus_enable, mem_write_enable, owner
  );

  modport master (
    output req_0_valid, req_0_address, req_0_write_enable, req_0_data_in,
    output req_1_valid, req_1_address, req_1_write_enable, req_1_data_in,
    output mem_data_out,
    input  req_0_ready, req_0_data_out, req_1_ready, req_1_data_out,
    input  mem_address, mem_data_in, mem_bus_enable, mem_write_enable, owner
  );

endinterface

// File: rtl/memory_arbiter_grant_select.sv
// Combinational winner choice: port 0 by default, port 1 once the burst limit is hit.
module grant_select
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               valid_0,
  input  logic               valid_1,
  input  logic [BURST_W-1:0] burst_count,
  output logic               winner,
  output logic [BURST_W-1:0] burst_next
);

  always_comb begin
    winner     = PORT_CPU;
    burst_next = burst_count;
    if (valid_1 && (!valid_0 || burst_count == BURST_W'(MAX_BURST))) begin
      winner     = PORT_AUX;
      burst_next = '0;
    end else if (valid_0) begin
      // Only grants made against a waiting port 1 count toward the burst limit.
      burst_next = valid_1 ? burst_count + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-port arbiter and access sequencer: serialises accesses and enforces read latency.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic             clk,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);

  state_t             state;
  logic [BURST_W-1:0] burst_count;
  logic [BURST_W-1:0] burst_next;
  logic [LAT_W-1:0]   lat_count;
  logic               winner;
  logic               write_flag;

  grant_select #(.MAX_BURST(MAX_BURST)) u_grant_select (
    .valid_0     (bus.req_0_valid),
    .valid_1     (bus.req_1_valid),
    .burst_count (burst_count),
    .winner      (winner),
    .burst_next  (burst_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      burst_count          <= '0;
      lat_count            <= '0;
      write_flag           <= 1'b0;
      bus.owner            <= PORT_CPU;
      bus.mem_address      <= '0;
      bus.mem_data_in      <= '0;
      bus.mem_bus_enable   <= 1'b0;
      bus.mem_write_enable <= 1'b0;
      bus.req_0_ready      <= 1'b0;
      bus.req_1_ready      <= 1'b0;
      bus.req_0_data_out   <= '0;
      bus.req_1_data_out   <= '0;
    end else begin
      bus.req_0_ready      <= 1'b0;
      bus.req_1_ready      <= 1'b0;
      bus.mem_bus_enable   <= 1'b0;
      bus.mem_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_0_valid || bus.req_1_valid) begin
            bus.owner   <= winner;
            burst_count <= burst_next;
            if (winner == PORT_AUX) begin
              bus.mem_address      <= bus.req_1_address;
              bus.mem_data_in      <= bus.req_1_data_in;
              bus.mem_write_enable <= bus.req_1_write_enable;
              write_flag           <= bus.req_1_write_enable;
            end else begin
              bus.mem_address      <= bus.req_0_address;
              bus.mem_data_in      <= bus.req_0_data_in;
              bus.mem_write_enable <= bus.req_0_write_enable;
              write_flag           <= bus.req_0_write_enable;
            end
            bus.mem_bus_enable <= 1'b1;
            state              <= ACCESS;
          end
        end
        ACCESS: begin
          lat_count <= write_flag ? lat_count : LAT_LOAD;
          if (write_flag || LAT_LOAD == '0) begin
            if (!write_flag) begin
              if (bus.owner == PORT_AUX) bus.req_1_data_out <= bus.mem_data_out;
              else                       bus.req_0_data_out <= bus.mem_data_out;
            end
            bus.req_0_ready <= (bus.owner == PORT_CPU);
            bus.req_1_ready <= (bus.owner == PORT_AUX);
            state           <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          lat_count <= lat_count - 1'b1;
          if (lat_count == LAT_W'(1)) begin
            if (bus.owner == PORT_AUX) bus.req_1_data_out <= bus.mem_data_out;
            else                       bus.req_0_data_out <= bus.mem_data_out;
            bus.req_0_ready <= (bus.owner == PORT_CPU);
            bus.req_1_ready <= (bus.owner == PORT_AUX);
            state           <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
